// File: rtl/cordic_result_unit.sv
// CORDIC result unit: undoes the front-end quadrant fold, buffers results in an FWFT FIFO
// and issues credits to the front end. Optional statistics ports: CORDIC_RESULT_STATS_EN.
module cordic_result_unit #(
  parameter int OUTPUT_WIDTH      = 16,
  parameter int OUTPUT_FRAC_WIDTH = 8,
  parameter int FLIP_FLAG_WIDTH   = 2,
  parameter int FIFO_DEPTH        = 8,
  parameter int PTR_WIDTH         = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic signed [OUTPUT_WIDTH-1:0]    degree_in,
  input  logic signed [OUTPUT_WIDTH-1:0]    x_in,
  input  logic signed [OUTPUT_WIDTH-1:0]    y_in,
  input  logic        [FLIP_FLAG_WIDTH-1:0] flip_in,
  input  logic                              arctan_en_in,
  input  logic                              valid_in,
  input  logic                              issue_in,
  output logic                              issue_ok,
  output logic signed [OUTPUT_WIDTH:0]      res_degree,
  output logic signed [OUTPUT_WIDTH-1:0]    res_x,
  output logic signed [OUTPUT_WIDTH-1:0]    res_y,
  output logic                              res_arctan,
  output logic                              res_valid,
  input  logic                              res_ready,
`ifdef CORDIC_RESULT_STATS_EN
  output logic        [15:0]                result_count,
  output logic        [PTR_WIDTH:0]         max_occupancy,
`endif
  output logic                              overflow_err
);

  localparam int DW = OUTPUT_WIDTH + 2;
  localparam int EW = 1 + (OUTPUT_WIDTH + 1) + 2 * OUTPUT_WIDTH;
  localparam logic signed [DW-1:0] DEG_180 = DW'(180 << OUTPUT_FRAC_WIDTH);
  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic signed [OUTPUT_WIDTH-1:0] MOST_NEG = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
  localparam logic signed [OUTPUT_WIDTH-1:0] MOST_POS = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};

  function automatic logic signed [OUTPUT_WIDTH-1:0] sat_neg(input logic signed [OUTPUT_WIDTH-1:0] v);
    if (v == MOST_NEG) sat_neg = MOST_POS;
    else               sat_neg = -v;
  endfunction

  logic signed [DW-1:0]           deg_c;
  logic signed [OUTPUT_WIDTH-1:0] x_c;
  logic signed [OUTPUT_WIDTH-1:0] y_c;
  logic [EW-1:0]                  wr_entry;

  // Unfold in order: flip[0] (half-plane mirror) first, then flip[1] (sign swap).
  always_comb begin
    deg_c = {{2{degree_in[OUTPUT_WIDTH-1]}}, degree_in};
    x_c   = x_in;
    y_c   = y_in;
    if (flip_in[0]) begin
      if (arctan_en_in) deg_c = !deg_c[DW-1] ? (DEG_180 - deg_c) : (-DEG_180 - deg_c);
      else              x_c   = sat_neg(x_in);
    end
    if (flip_in[1]) begin
      if (arctan_en_in) deg_c = -deg_c;
      else              y_c   = sat_neg(y_in);
    end
    wr_entry = {arctan_en_in, deg_c[OUTPUT_WIDTH:0], x_c, y_c};
  end

  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0]     count, count_nxt;
  logic [PTR_WIDTH:0]     outstanding, outstanding_nxt;
  logic                   full, pop, push_ok, drop, credit_err;
  logic [EW-1:0]          head;

  // Consumer handshake: a result transfers on any rising edge where res_valid && res_ready;
  // res_* are stable while res_valid is high and res_ready is low.
  assign full       = (count == DEPTH_C);
  assign res_valid  = (count != '0);
  assign pop        = res_valid & res_ready;
  assign push_ok    = valid_in & (~full | pop);
  assign drop       = valid_in & full & ~pop;
  assign issue_ok   = (outstanding < DEPTH_C);
  assign credit_err = issue_in & ~issue_ok;

  assign head       = mem[rd_ptr];
  assign res_arctan = head[EW-1];
  assign res_degree = head[EW-2 -: OUTPUT_WIDTH+1];
  assign res_x      = head[2*OUTPUT_WIDTH-1 -: OUTPUT_WIDTH];
  assign res_y      = head[OUTPUT_WIDTH-1:0];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Credit saturates at FIFO_DEPTH on over-issue and at 0 on a stray pop.
  always_comb begin
    outstanding_nxt = outstanding;
    case ({issue_in, pop})
      2'b10:   if (issue_ok) outstanding_nxt = outstanding + 1'b1;
      2'b01:   if (outstanding != '0) outstanding_nxt = outstanding - 1'b1;
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      outstanding  <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      outstanding <= outstanding_nxt;
      if (drop | credit_err) overflow_err <= 1'b1;
    end
  end

`ifdef CORDIC_RESULT_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_count  <= '0;
      max_occupancy <= '0;
    end else begin
      if (pop && result_count != 16'hFFFF) result_count <= result_count + 16'd1;
      if (count_nxt > max_occupancy) max_occupancy <= count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_cordic_result_unit.sv
// Bench for cordic_result_unit: table-driven correction vectors, backpressure, wrap/order
// and asynchronous reset sequences, checked through an expected-result queue.
module tb_cordic_result_unit;

  localparam int EW = 50;

  logic               clk, reset;
  logic signed [15:0] degree_in, x_in, y_in;
  logic [1:0]         flip_in;
  logic               arctan_en_in, valid_in, issue_in, res_ready;
  logic               issue_ok, res_arctan, res_valid, overflow_err;
  logic signed [16:0] res_degree;
  logic signed [15:0] res_x, res_y;

  int n_vec  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  cordic_result_unit dut (
    .clk(clk), .reset(reset), .degree_in(degree_in), .x_in(x_in), .y_in(y_in),
    .flip_in(flip_in), .arctan_en_in(arctan_en_in), .valid_in(valid_in),
    .issue_in(issue_in), .issue_ok(issue_ok), .res_degree(res_degree),
    .res_x(res_x), .res_y(res_y), .res_arctan(res_arctan), .res_valid(res_valid),
    .res_ready(res_ready), .overflow_err(overflow_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input int d, input int x, input int y, input logic at);
    logic [16:0] d17;
    logic [15:0] x16, y16;
    d17 = 17'(d);
    x16 = 16'(x);
    y16 = 16'(y);
    return {at, d17, x16, y16};
  endfunction

  function automatic logic [EW-1:0] model(input int d, input int x, input int y,
                                          input logic [1:0] f, input logic at);
    int dd, xx, yy;
    dd = d; xx = x; yy = y;
    if (f[0]) begin
      if (at) dd = (dd >= 0) ? (46080 - dd) : (-46080 - dd);
      else    xx = (xx == -32768) ? 32767 : -xx;
    end
    if (f[1]) begin
      if (at) dd = -dd;
      else    yy = (yy == -32768) ? 32767 : -yy;
    end
    return pack(dd, xx, yy, at);
  endfunction

  // Scoreboard: compare the head whenever it will be popped on the next rising edge.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (reset && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("res_degree", res_degree, $signed(e[48:32]));
          chk("res_x", res_x, $signed(e[31:16]));
          chk("res_y", res_y, $signed(e[15:0]));
          chk("res_arctan", res_arctan, e[49]);
        end
      end
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int d, input int x, input int y, input logic [1:0] f,
                          input logic at, input logic iss);
    degree_in    = 16'(d);
    x_in         = 16'(x);
    y_in         = 16'(y);
    flip_in      = f;
    arctan_en_in = at;
    valid_in     = 1'b1;
    issue_in     = iss;
  endtask

  task automatic beat(input int d, input int x, input int y, input logic [1:0] f,
                      input logic at, input logic iss, input logic [EW-1:0] e);
    set_beat(d, x, y, f, at, iss);
    exp_q.push_back(e);
    cyc();
    valid_in = 1'b0;
    issue_in = 1'b0;
  endtask

  task automatic drain(input string name);
    res_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc();
    chk({name, "_drain_left"}, exp_q.size(), 0);
    cyc();
    cyc();
    chk({name, "_empty_valid"}, res_valid, 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_issue_ok", issue_ok, 1);
    chk("rst_overflow_err", overflow_err, 0);
    #13 reset = 1'b1;
    cyc();
  endtask

  typedef struct {
    int d, x, y;
    logic [1:0] f;
    logic at;
    int ed, ex, ey;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int sent;
    vecs[0]  = '{7680, 222, 128, 2'b01, 1'b0, 7680, -222, 128};
    vecs[1]  = '{11520, 362, 0, 2'b01, 1'b1, 34560, 362, 0};
    vecs[2]  = '{11520, 362, 0, 2'b11, 1'b1, -34560, 362, 0};
    vecs[3]  = '{-11520, 362, 0, 2'b01, 1'b1, -34560, 362, 0};
    vecs[4]  = '{0, -32768, -32768, 2'b11, 1'b0, 0, 32767, 32767};
    vecs[5]  = '{100, 5, 7, 2'b10, 1'b0, 100, 5, -7};
    vecs[6]  = '{2560, 300, 3, 2'b10, 1'b1, -2560, 300, 3};
    vecs[7]  = '{-5000, 10, -10, 2'b00, 1'b1, -5000, 10, -10};
    vecs[8]  = '{0, 1, 2, 2'b01, 1'b1, 46080, 1, 2};
    vecs[9]  = '{0, 1, 2, 2'b11, 1'b1, -46080, 1, 2};
    vecs[10] = '{32767, 4, 4, 2'b01, 1'b1, 13313, 4, 4};
    vecs[11] = '{-32768, 4, 4, 2'b01, 1'b1, -13312, 4, 4};
    vecs[12] = '{-32768, 4, 4, 2'b11, 1'b1, 13312, 4, 4};
    vecs[13] = '{-9, 32767, -32767, 2'b11, 1'b0, -9, -32767, 32767};

    reset = 1'b0;
    degree_in = '0; x_in = '0; y_in = '0; flip_in = '0;
    arctan_en_in = 1'b0; valid_in = 1'b0; issue_in = 1'b0; res_ready = 1'b0;
    #3;
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_degree", res_degree, 0);
    chk("reset_res_x", res_x, 0);
    chk("reset_res_y", res_y, 0);
    chk("reset_res_arctan", res_arctan, 0);
    chk("reset_issue_ok", issue_ok, 1);
    chk("reset_overflow_err", overflow_err, 0);
    #20 reset = 1'b1;
    cyc();

    // First beat: one-cycle latency into an empty FIFO
    res_ready = 1'b1;
    set_beat(vecs[0].d, vecs[0].x, vecs[0].y, vecs[0].f, vecs[0].at, 1'b1);
    exp_q.push_back(pack(vecs[0].ed, vecs[0].ex, vecs[0].ey, vecs[0].at));
    chk("latency_before", res_valid, 0);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    issue_in = 1'b0;
    @(negedge clk);
    chk("latency_valid", res_valid, 1);
    cyc();

    for (int i = 1; i < 14; i++)
      beat(vecs[i].d, vecs[i].x, vecs[i].y, vecs[i].f, vecs[i].at, 1'b1,
           pack(vecs[i].ed, vecs[i].ex, vecs[i].ey, vecs[i].at));
    drain("table");

    // Backpressure: fill, over-issue, then drain
    res_ready = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("bp_issue_ok_7", issue_ok, 1);
      beat(256 * i, 1000 + i, -i, 2'b00, 1'b0, 1'b1, pack(256 * i, 1000 + i, -i, 1'b0));
    end
    chk("bp_issue_ok_full", issue_ok, 0);
    chk("bp_err_before", overflow_err, 0);
    issue_in = 1'b1;
    cyc();
    issue_in = 1'b0;
    chk("bp_overflow_err", overflow_err, 1);
    chk("bp_issue_ok_sat", issue_ok, 0);
    res_ready = 1'b1;
    cyc();
    chk("bp_issue_ok_after_pop", issue_ok, 1);
    drain("bp");
    chk("bp_err_sticky", overflow_err, 1);

    async_reset();

    // Wrap and ordering with random backpressure
    sent = 0;
    for (int c = 0; c < 3000 && sent < 40; c++) begin
      res_ready = 1'($urandom_range(0, 1));
      if (issue_ok) begin
        int d, x, y;
        logic [1:0] f;
        logic at;
        d  = int'($urandom_range(0, 65535)) - 32768;
        x  = sent * 37 - 700;
        y  = int'($urandom_range(0, 65535)) - 32768;
        f  = 2'($urandom_range(0, 3));
        at = 1'($urandom_range(0, 1));
        set_beat(d, x, y, f, at, 1'b1);
        exp_q.push_back(model(d, x, y, f, at));
        sent++;
      end
      cyc();
      valid_in = 1'b0;
      issue_in = 1'b0;
    end
    chk("wrap_sent", sent, 40);
    drain("wrap");
    chk("wrap_overflow_err", overflow_err, 0);

    // Push and pop in the same edge while full
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      beat(0, 2000 + i, i, 2'b00, 1'b0, 1'b1, pack(0, 2000 + i, i, 1'b0));
    res_ready = 1'b1;
    beat(0, 3000, 9, 2'b00, 1'b0, 1'b0, pack(0, 3000, 9, 1'b0));
    res_ready = 1'b0;
    cyc();
    chk("fullpp_overflow_err", overflow_err, 0);
    chk("fullpp_valid", res_valid, 1);
    drain("fullpp");
    chk("fullpp_issue_ok", issue_ok, 1);

    // Reset mid-operation with 5 entries stored
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      beat(0, 4000 + i, 0, 2'b00, 1'b0, 1'b1, pack(0, 4000 + i, 0, 1'b0));
    chk("mid_valid_before", res_valid, 1);
    async_reset();
    res_ready = 1'b1;
    set_beat(7680, 55, 66, 2'b01, 1'b0, 1'b1);
    exp_q.push_back(pack(7680, -55, 66, 1'b0));
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    issue_in = 1'b0;
    @(negedge clk);
    chk("mid_latency_valid", res_valid, 1);
    cyc();
    drain("mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
